// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Brief    : Shared state encoding, default operand width and counter sizing
//             for the signed shift-add multiplier sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int MULT_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_ADD   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Iteration counter must hold WIDTH without wrapping.
    function automatic int count_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mult_seq_ctrl_if
//  Brief    : Switch/button inputs and display-side register outputs of the
//             multiplier sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             Run;
    logic             ClearA_LoadB;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             Xval;
    logic             Busy;
    logic             Done;

    modport master (
        output Run, ClearA_LoadB, S,
        input  Aval, Bval, Xval, Busy, Done
    );

    modport slave (
        input  Run, ClearA_LoadB, S,
        output Aval, Bval, Xval, Busy, Done
    );
endinterface
`default_nettype wire

// File: rtl/mult_seq_ctrl_add_sub_step.sv
`default_nettype none
// ============================================================================
//  Module   : add_sub_step
//  Brief    : Combinational WIDTH+1-bit sign-extending add/subtract of S to A.
//  Revision : 1.0 - initial release
// ============================================================================
module add_sub_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic             sub_i,
    output logic [WIDTH:0]   r_o
);
    logic [WIDTH:0] w_a_ext;
    logic [WIDTH:0] w_s_ext;
    logic [WIDTH:0] w_s_op;

    assign w_a_ext = {a_i[WIDTH-1], a_i};
    assign w_s_ext = {s_i[WIDTH-1], s_i};
    assign w_s_op  = sub_i ? ~w_s_ext : w_s_ext;
    // Carry-out is dropped; the +1 completes the two's-complement negate.
    assign r_o     = w_a_ext + w_s_op + {{WIDTH{1'b0}}, sub_i};
endmodule
`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mult_seq_ctrl
//  Brief    : Signed shift-add multiplier sequencer owning the X/A/B registers.
//             Optional MULT_SKIP_ADD_EN skips ADD when the multiplier bit is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic           Clk,
    input  logic           Reset_n,
    mult_seq_ctrl_if.slave bus
);
    localparam int CW = count_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             x_q, x_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_w;
    logic [WIDTH:0]   sum_w;

    assign last_w = (cnt_q == CW'(WIDTH - 1));

    // The final iteration carries the negative sign-bit weight, hence subtract.
    add_sub_step #(.WIDTH(WIDTH)) u_add_sub (
        .a_i   (a_q),
        .s_i   (bus.S),
        .sub_i (last_w),
        .r_o   (sum_w)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Run) begin
                    state_d = ST_CLR;
                    a_d     = '0;
                    x_d     = 1'b0;
                    cnt_d   = '0;
                end else if (bus.ClearA_LoadB) begin
                    a_d = '0;
                    x_d = 1'b0;
                    b_d = bus.S;
                end
            end
            ST_CLR: begin
`ifdef MULT_SKIP_ADD_EN
                state_d = b_q[0] ? ST_ADD : ST_SHIFT;
`else
                state_d = ST_ADD;
`endif
            end
            ST_ADD: begin
                if (b_q[0]) begin
                    a_d = sum_w[WIDTH-1:0];
                    x_d = sum_w[WIDTH];
                end
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                a_d   = {x_q, a_q[WIDTH-1:1]};
                b_d   = {a_q[0], b_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last_w) begin
                    state_d = ST_HOLD;
                end else begin
`ifdef MULT_SKIP_ADD_EN
                    // b_q[1] is the multiplier bit that lands in B[0] after this shift.
                    state_d = b_q[1] ? ST_ADD : ST_SHIFT;
`else
                    state_d = ST_ADD;
`endif
                end
            end
            ST_HOLD: begin
                if (!bus.Run) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they align with it.
    always_comb begin
        busy_d = (state_d == ST_CLR) || (state_d == ST_ADD) || (state_d == ST_SHIFT);
        done_d = (state_d == ST_HOLD);
    end

    assign bus.Aval = a_q;
    assign bus.Bval = b_q;
    assign bus.Xval = x_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_seq_ctrl
//  Brief    : Self-checking bench for mult_seq_ctrl (either MULT_SKIP_ADD_EN build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_seq_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;

    mult_seq_ctrl_if #(.WIDTH(W)) bus ();

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b_load;
        logic [7:0] s_run;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic       exp_x;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_busy(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
`ifdef MULT_SKIP_ADD_EN
        return 1 + W + ones;
`else
        return 1 + 2 * W + 0 * ones;
`endif
    endfunction

    task automatic load_b(input logic [7:0] b);
        @(negedge clk);
        bus.ClearA_LoadB = 1'b1;
        bus.S            = b;
        @(negedge clk);
        bus.ClearA_LoadB = 1'b0;
    endtask

    // Starts a run, counts Busy cycles until Done, releases Run.
    task automatic run_mult(input logic [7:0] s, input logic [7:0] s_late,
                            output int busy_cycles, output bit timed_out);
        int guard;
        bus.Run = 1'b1;
        bus.S   = s;
        busy_cycles = 0;
        timed_out   = 1'b0;
        guard       = 0;
        @(negedge clk);
        while (!bus.Done && guard < 100) begin
            if (bus.Busy) begin
                if (busy_cycles == 0) bus.S = s_late;
                busy_cycles++;
            end
            guard++;
            @(negedge clk);
        end
        if (!bus.Done) timed_out = 1'b1;
        bus.Run = 1'b0;
    endtask

    initial begin
        int  bc;
        bit  to;
        n_vec  = 0;
        n_fail = 0;

        vecs[0] = '{8'hFD, 8'h07, 8'hFF, 8'hEB, 1'b1};
        vecs[1] = '{8'h80, 8'h80, 8'h40, 8'h00, 1'b0};
        vecs[2] = '{8'h7F, 8'h7F, 8'h3F, 8'h01, 1'b0};
        vecs[3] = '{8'h00, 8'h5A, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'h01, 8'h05, 8'h00, 8'h05, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0};
        vecs[6] = '{8'h80, 8'h7F, 8'hC0, 8'h80, 1'b1};
        vecs[7] = '{8'h05, 8'hFD, 8'hFF, 8'hF1, 1'b1};

        bus.Run          = 1'b0;
        bus.ClearA_LoadB = 1'b0;
        bus.S            = 8'h00;
        rst_n            = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_A", int'(bus.Aval), 0);
        check("reset_B", int'(bus.Bval), 0);
        check("reset_XBD", int'({bus.Xval, bus.Busy, bus.Done}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            load_b(vecs[i].b_load);
            check($sformatf("v%0d_loadB", i), int'(bus.Bval), int'(vecs[i].b_load));
            run_mult(vecs[i].s_run, vecs[i].s_run, bc, to);
            check($sformatf("v%0d_timeout", i), int'(to), 0);
            check($sformatf("v%0d_busy", i), bc, exp_busy(vecs[i].b_load));
            check($sformatf("v%0d_prod", i), int'({bus.Xval, bus.Aval, bus.Bval}),
                  int'({vecs[i].exp_x, vecs[i].exp_a, vecs[i].exp_b}));
            @(negedge clk);
            check($sformatf("v%0d_idle", i), int'({bus.Busy, bus.Done}), 0);
        end

        // Live S: multiplier 2 only adds in iteration 1, after S has changed to 3.
        load_b(8'h02);
        run_mult(8'h11, 8'h03, bc, to);
        check("live_s_prod", int'({bus.Aval, bus.Bval}), 16'h0006);

        // Run held for 40 cycles, ClearA_LoadB pulsed while busy.
        load_b(8'h03);
        bus.Run = 1'b1;
        bus.S   = 8'h03;
        bc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.ClearA_LoadB = (c >= 3 && c <= 5);
            if (c >= 3 && c <= 5) bus.S = 8'h03;
            if (bus.Busy) bc++;
        end
        bus.ClearA_LoadB = 1'b0;
        check("held_busy", bc, exp_busy(8'h03));
        check("held_done", int'(bus.Done), 1);
        check("held_prod", int'({bus.Xval, bus.Aval, bus.Bval}), 17'h00009);
        bus.Run = 1'b0;
        @(negedge clk);
        check("held_release", int'({bus.Busy, bus.Done}), 0);
        check("held_B_kept", int'(bus.Bval), 9);

        // Asynchronous reset in the middle of a run.
        load_b(8'h07);
        bus.Run = 1'b1;
        bus.S   = 8'h03;
        repeat (6) @(negedge clk);
        check("mid_busy", int'(bus.Busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outs", int'({bus.Xval, bus.Aval, bus.Bval, bus.Busy, bus.Done}), 0);
        bus.Run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_mult(8'h6B, 8'h6B, bc, to);
        check("arst_timeout", int'(to), 0);
        check("arst_busy", bc, exp_busy(8'h00));
        check("arst_prod", int'({bus.Xval, bus.Aval, bus.Bval}), 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequencer for the signed shift-add multiplier datapath: owns the X/A/B registers and steps a WIDTH+1-bit add/subtract unit through WIDTH add/shift iterations to form a 2·WIDTH-bit two's-complement product in {A,B}. It sits between the switch/button inputs (S, Run, ClearA_LoadB) and the hex/LED display logic, which reads Aval, Bval and Xval directly.

## Interface
- WIDTH, 8, operand width in bits; product width is 2·WIDTH
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Run  in  1  level; a rising-edge detection is not required, the FSM start condition is Run=1 while in IDLE
- ClearA_LoadB  in  1  level; honoured only in IDLE
- S  in  WIDTH  multiplicand, also the load value for B
- Aval  out  WIDTH  A register (product high half)
- Bval  out  WIDTH  B register (multiplier, then product low half)
- Xval  out  1  X sign-extension register
- Busy  out  1  high from CLR through the last SHIFT inclusive
- Done  out  1  high in HOLD

## Operation
- Reset (async): A=0, B=0, X=0, state=IDLE, count=0; Busy=0, Done=0.
- IDLE, ClearA_LoadB=1 and Run=0: A←0, X←0, B←S. If both are 1, Run wins and ClearA_LoadB is ignored.
- IDLE, Run=1 → CLR: A←0, X←0 (B retained), count←0.
- CLR → ADD.
- ADD: if B[0]=1, compute R = {A[W-1],A} + {S[W-1],S} for count<WIDTH-1, and R = {A[W-1],A} − {S[W-1],S} for count=WIDTH-1 (sign-bit weight). Then A←R[W-1:0] and X←R[W]. If B[0]=0, A and X are unchanged. Next state is SHIFT.
- SHIFT: arithmetic right shift of {X,A,B} by one; X keeps its value, A[W-1]←X, B[W-1]←A[0]. count←count+1. If the old count=WIDTH-1, go to HOLD, else go to ADD.
- HOLD: registers frozen, Done=1; remain until Run=0, then go to IDLE. A held Run never causes a second multiply.
- S and ClearA_LoadB are sampled every cycle but ignored outside IDLE. The bench must be able to change S mid-run with the product still using the live S; the team sources S from static switches.
- Arithmetic: the add/sub unit is WIDTH+1 bits wide with carry-out discarded. Subtraction is A + ~S + 1 on the sign-extended operands.
- The result {A,B} is the exact signed product for all operand pairs, including −2^(W−1)·−2^(W−1). X equals A[W-1] after completion.
- count width is $clog2(WIDTH)+1; there is no wrap within a run.

## Timing
- Run sampled high in IDLE: CLR occurs on the next cycle.
- Busy duration: 1 + 2·WIDTH cycles (17 for WIDTH=8).
- Done asserts on the cycle after the last SHIFT.
- Outputs are registered; they change only on a clock edge or on reset assertion.
- Reset_n low at any point, including mid-run, restores the reset values immediately. After Reset_n is released, the block sits in IDLE; if Run is still high, a new run starts on the next edge.

## Configuration
- MULT_SKIP_ADD_EN defined: the ADD state is skipped when B[0]=0. SHIFT then goes directly to the next SHIFT, and CLR goes directly to SHIFT, whenever the B[0] value entering the iteration is 0. Busy duration becomes 1 + WIDTH + popcount(initial B) cycles. Final register values are identical to the undefined case.
- Undefined: fixed 1 + 2·WIDTH busy cycles regardless of operands.

## Structure
- Shared package mult_pkg contains the state enum (IDLE, CLR, ADD, SHIFT, HOLD), the default WIDTH constant, and a function for the count width.
- One sub-module: add_sub_step, a combinational WIDTH+1-bit sign-extending add/subtract. Its inputs are A, S and sub; its outputs are R[WIDTH:0].
- The FSM, counter and X/A/B registers live in mult_seq_ctrl.

## Test plan
- ClearA_LoadB=1 with S=0xFD, then Run with S=0x07: 17 cycles later Aval=0xFF, Bval=0xEB, Xval=1 (−21), Done=1.
- B=0x80, S=0x80: product 0x4000 (Aval=0x40, Bval=0x00, Xval=0).
- B=0x7F, S=0x7F: product 0x3F01. Then B=0x00 with any S: product 0x0000, X=0.
- Run held high for 40 cycles: exactly one multiply; Done is held until Run falls, then IDLE; ClearA_LoadB pulsed while Busy has no effect.
- Reset_n pulled low at cycle 6 of a run: all outputs are 0 asynchronously, state is IDLE, and the next Run with B=0 yields a zero product.
- With MULT_SKIP_ADD_EN and B=0x01, S=0x05: Busy lasts 10 cycles, product 0x0005. With B=0x00: Busy lasts 9 cycles.
